// File: rtl/mem_stage_if.sv
// mem_stage_if: data-RAM request/acknowledge bus between the MEM stage and the data RAM.
//
// Handshake: the master raises dram_req together with dram_wr, dram_addr, dram_wstrb
// and dram_wdata, and holds all of them stable until it samples dram_ack high on a
// rising clock edge. The slave may assert dram_ack in any cycle in which dram_req is
// high. The acknowledge completes the access in that cycle. For reads, dram_rdata must
// be valid in the same cycle as dram_ack. dram_ack is ignored while dram_req is low.
// A request may be withdrawn without an acknowledge only by reset.
interface mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dram_req;
    logic              dram_wr;
    logic [ADDR_W-1:0] dram_addr;
    logic [3:0]        dram_wstrb;
    logic [31:0]       dram_wdata;
    logic              dram_ack;
    logic [31:0]       dram_rdata;

    modport master (
        output dram_req,
        output dram_wr,
        output dram_addr,
        output dram_wstrb,
        output dram_wdata,
        input  dram_ack,
        input  dram_rdata
    );

    modport slave (
        input  dram_req,
        input  dram_wr,
        input  dram_addr,
        input  dram_wstrb,
        input  dram_wdata,
        output dram_ack,
        output dram_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Takes the EX/MEM entry and runs one data-RAM access per memory instruction.
// Handles store lane alignment and load extension, and owns the LL/SC link bit.
// Registers the MEM/WB result. Holds the upstream stage with mem_stall while an
// access is outstanding.
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        valid_in,
    input  logic [4:0]  wR_in,
    input  logic [31:0] pc4_in,
    input  logic [31:0] alu_C_in,
    input  logic [31:0] rD2_in,
    input  logic [31:0] ext_in,
    input  logic        rf_we_in,
    input  logic [1:0]  wd_sel_in,
    input  logic [3:0]  ram_we_in,
    input  logic [2:0]  ram_ext_op_in,
    input  logic        ll_in,
    input  logic        sc_in,
    input  logic        llbit_clr,
    mem_stage_if.master dram,
    output logic        mem_stall,
    output logic        addr_err,
    output logic        valid_out,
    output logic [4:0]  wR_out,
    output logic        rf_we_out,
    output logic [31:0] wd_out,
    output logic [0:0]  dbg_state_o,
    output logic        dbg_llbit_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_LW  = 3'b101;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC4 = 2'b10;
    localparam logic [1:0] SEL_EXT = 2'b11;

    logic [0:0]  state_q, state_d;
    logic        llbit_q, llbit_d;

    // MEM/WB result registers
    logic        valid_out_q, valid_out_d;
    logic [4:0]  wR_out_q, wR_out_d;
    logic        rf_we_out_q, rf_we_out_d;
    logic [31:0] wd_out_q, wd_out_d;
    logic        addr_err_q, addr_err_d;

    // Entry fields captured when an access starts, used for the whole REQ phase
    logic [31:0] alu_c_q;
    logic [31:0] pc4_q;
    logic [31:0] ext_q;
    logic [4:0]  wr_q;
    logic        rf_we_q;
    logic [1:0]  wd_sel_q;
    logic [2:0]  ext_op_q;
    logic        wr_en_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic        ll_q;
    logic        sc_q;

    logic        is_mem, is_half, is_word, misaligned, sc_fail, go_req, done;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [31:0] pass_wd;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] done_wd;

    // Classify the incoming entry and decide whether it needs a bus access
    always_comb begin
        is_mem     = valid_in && (ram_we_in != 4'b0000 || ram_ext_op_in != 3'b000);
        is_half    = (ram_we_in == 4'b0011) || (ram_ext_op_in == OP_LH) || (ram_ext_op_in == OP_LHU);
        is_word    = (ram_we_in == 4'b1111) || (ram_ext_op_in == OP_LW);
        misaligned = is_mem && ((is_half && alu_C_in[0]) || (is_word && (alu_C_in[1:0] != 2'b00)));
        sc_fail    = valid_in && sc_in && !llbit_q;
        go_req     = (state_q == IDLE) && is_mem && !misaligned && !sc_fail;
        done       = (state_q == REQ) && dram.dram_ack;
    end

    // Store lane placement: strobes shifted to the byte offset, data replicated per size
    always_comb begin
        wstrb_d = ram_we_in << alu_C_in[1:0];
        case (ram_we_in)
            4'b0001: wdata_d = {4{rD2_in[7:0]}};
            4'b0011: wdata_d = {2{rD2_in[15:0]}};
            default: wdata_d = rD2_in;
        endcase
    end

    // Write-back value for entries that complete without a bus access
    always_comb begin
        case (wd_sel_in)
            SEL_ALU: pass_wd = alu_C_in;
            SEL_PC4: pass_wd = pc4_in;
            SEL_EXT: pass_wd = ext_in;
            default: pass_wd = 32'h0;
        endcase
        if (sc_fail && !misaligned) begin
            pass_wd = 32'h0;
        end
    end

    // Load lane selection and extension from the captured address and op
    always_comb begin
        case (alu_c_q[1:0])
            2'b00:   ld_byte = dram.dram_rdata[7:0];
            2'b01:   ld_byte = dram.dram_rdata[15:8];
            2'b10:   ld_byte = dram.dram_rdata[23:16];
            default: ld_byte = dram.dram_rdata[31:24];
        endcase
        ld_half = alu_c_q[1] ? dram.dram_rdata[31:16] : dram.dram_rdata[15:0];
        case (ext_op_q)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'h0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'h0, ld_half};
            OP_LW:   ld_data = dram.dram_rdata;
            default: ld_data = 32'h0;
        endcase
    end

    // Write-back value for an access completing on acknowledge; a successful SC returns 1
    always_comb begin
        case (wd_sel_q)
            SEL_ALU: done_wd = alu_c_q;
            SEL_MEM: done_wd = ld_data;
            SEL_PC4: done_wd = pc4_q;
            default: done_wd = ext_q;
        endcase
        if (sc_q) begin
            done_wd = 32'h1;
        end
    end

    // Next state: leave IDLE on an accepted access, return on acknowledge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go_req) state_d = REQ;
            REQ:     if (dram.dram_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next MEM/WB contents: one-cycle pass, bubble while waiting, result on acknowledge
    always_comb begin
        valid_out_d = 1'b0;
        wR_out_d    = wR_out_q;
        rf_we_out_d = 1'b0;
        wd_out_d    = wd_out_q;
        addr_err_d  = 1'b0;
        if (state_q == IDLE) begin
            if (!go_req) begin
                valid_out_d = valid_in;
                wR_out_d    = wR_in;
                rf_we_out_d = valid_in && rf_we_in && !misaligned;
                wd_out_d    = pass_wd;
                addr_err_d  = misaligned;
            end
        end else if (done) begin
            valid_out_d = 1'b1;
            wR_out_d    = wr_q;
            rf_we_out_d = rf_we_q;
            wd_out_d    = done_wd;
        end
    end

    // Link bit: clear request wins over an LL completing in the same cycle
    always_comb begin
        llbit_d = llbit_q;
        if (llbit_clr) begin
            llbit_d = 1'b0;
        end else if (done && ll_q) begin
            llbit_d = 1'b1;
        end else if (done && sc_q) begin
            llbit_d = 1'b0;
        end else if ((state_q == IDLE) && valid_in && sc_in && !go_req) begin
            llbit_d = 1'b0;
        end
    end

    // State, link bit and MEM/WB registers
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q     <= IDLE;
            llbit_q     <= 1'b0;
            valid_out_q <= 1'b0;
            wR_out_q    <= 5'h0;
            rf_we_out_q <= 1'b0;
            wd_out_q    <= 32'h0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            llbit_q     <= llbit_d;
            valid_out_q <= valid_out_d;
            wR_out_q    <= wR_out_d;
            rf_we_out_q <= rf_we_out_d;
            wd_out_q    <= wd_out_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Capture the entry when an access starts so the bus stays stable during REQ
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            alu_c_q  <= 32'h0;
            pc4_q    <= 32'h0;
            ext_q    <= 32'h0;
            wr_q     <= 5'h0;
            rf_we_q  <= 1'b0;
            wd_sel_q <= 2'b00;
            ext_op_q <= 3'b000;
            wr_en_q  <= 1'b0;
            wstrb_q  <= 4'h0;
            wdata_q  <= 32'h0;
            ll_q     <= 1'b0;
            sc_q     <= 1'b0;
        end else if (go_req) begin
            alu_c_q  <= alu_C_in;
            pc4_q    <= pc4_in;
            ext_q    <= ext_in;
            wr_q     <= wR_in;
            rf_we_q  <= rf_we_in;
            wd_sel_q <= wd_sel_in;
            ext_op_q <= ram_ext_op_in;
            wr_en_q  <= (ram_we_in != 4'b0000);
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            ll_q     <= ll_in;
            sc_q     <= sc_in;
        end
    end

    // Bus and stall outputs; the request drops as soon as reset clears the state
    always_comb begin
        dram.dram_req   = (state_q == REQ);
        dram.dram_wr    = wr_en_q;
        dram.dram_addr  = {alu_c_q[ADDR_W-1:2], 2'b00};
        dram.dram_wstrb = wstrb_q;
        dram.dram_wdata = wdata_q;
        mem_stall       = !cpu_rst && (go_req || ((state_q == REQ) && !dram.dram_ack));
    end

    assign valid_out   = valid_out_q;
    assign wR_out      = wR_out_q;
    assign rf_we_out   = rf_we_out_q;
    assign wd_out      = wd_out_q;
    assign addr_err    = addr_err_q;
    assign dbg_state_o = state_q;
    assign dbg_llbit_o = llbit_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with a behavioural RAM slave.
module tb_mem_stage;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [4:0]  wR_in = '0;
    logic [31:0] pc4_in = '0, alu_C_in = '0, rD2_in = '0, ext_in = '0;
    logic        rf_we_in = 1'b0;
    logic [1:0]  wd_sel_in = '0;
    logic [3:0]  ram_we_in = '0;
    logic [2:0]  ram_ext_op_in = '0;
    logic        ll_in = 1'b0, sc_in = 1'b0, llbit_clr = 1'b0;
    logic        mem_stall, addr_err, valid_out, rf_we_out, dbg_llbit_o;
    logic [4:0]  wR_out;
    logic [31:0] wd_out;
    logic [0:0]  dbg_state_o;

    mem_stage_if #(.ADDR_W(32)) dram_bus ();

    mem_stage #(.ADDR_W(32)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .valid_in(valid_in), .wR_in(wR_in),
        .pc4_in(pc4_in), .alu_C_in(alu_C_in), .rD2_in(rD2_in), .ext_in(ext_in),
        .rf_we_in(rf_we_in), .wd_sel_in(wd_sel_in), .ram_we_in(ram_we_in),
        .ram_ext_op_in(ram_ext_op_in), .ll_in(ll_in), .sc_in(sc_in), .llbit_clr(llbit_clr),
        .dram(dram_bus), .mem_stall(mem_stall), .addr_err(addr_err), .valid_out(valid_out),
        .wR_out(wR_out), .rf_we_out(rf_we_out), .wd_out(wd_out),
        .dbg_state_o(dbg_state_o), .dbg_llbit_o(dbg_llbit_o)
    );

    // ---------------- clock / reset ----------------
    always #5 cpu_clk = ~cpu_clk;

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [38:0] exp_q[$];   // {addr_err, rf_we, wR, wd}
    logic [68:0] bus_q[$];   // {wr, wstrb, addr, wdata}
    logic [31:0] ram_w[logic [31:0]];
    logic [7:0]  gold_b[logic [31:0]];
    bit          m_link = 1'b0;
    int          wait_left = -1;
    int          force_delay = -1;
    int          req_cnt = 0;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wstrb;
    logic        last_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [7:0] gold_byte(input logic [31:0] a);
        logic [31:0] w;
        if (gold_b.exists(a)) return gold_b[a];
        w = init_word({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    function automatic int acc_size(input logic [3:0] we, input logic [2:0] op);
        if (we == 4'b0001) return 1;
        if (we == 4'b0011) return 2;
        if (we == 4'b1111) return 4;
        case (op)
            3'd1, 3'd2: return 1;
            3'd3, 3'd4: return 2;
            3'd5:       return 4;
            default:    return 0;
        endcase
    endfunction

    // ---------------- RAM slave ----------------
    initial begin
        dram_bus.dram_ack   = 1'b0;
        dram_bus.dram_rdata = 32'h0;
        forever begin
            logic [68:0] e;
            logic [31:0] w;
            @(posedge cpu_clk);
            #1;
            dram_bus.dram_ack = 1'b0;
            if (dram_bus.dram_req && !cpu_rst) begin
                if (wait_left < 0) wait_left = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                if (wait_left == 0) begin
                    wait_left = -1;
                    req_cnt++;
                    last_addr  = dram_bus.dram_addr;
                    last_wstrb = dram_bus.dram_wstrb;
                    last_wdata = dram_bus.dram_wdata;
                    last_wr    = dram_bus.dram_wr;
                    w = ram_w.exists(last_addr) ? ram_w[last_addr] : init_word(last_addr);
                    dram_bus.dram_rdata = w;
                    dram_bus.dram_ack   = 1'b1;
                    if (bus_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL bus_unexpected: got req addr %h expected none", last_addr);
                    end else begin
                        e = bus_q.pop_front();
                        chk("bus_wr", {31'h0, last_wr}, {31'h0, e[68]});
                        chk("bus_addr", last_addr, e[63:32]);
                        chk("bus_wstrb", {28'h0, last_wstrb}, {28'h0, e[67:64]});
                        if (e[68]) chk("bus_wdata", last_wdata, e[31:0]);
                    end
                    if (last_wr) begin
                        for (int i = 0; i < 4; i++)
                            if (last_wstrb[i]) w[8*i +: 8] = last_wdata[8*i +: 8];
                        ram_w[last_addr] = w;
                    end
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge cpu_clk) begin
        logic [38:0] e;
        if (!cpu_rst) begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL out_unexpected: got valid_out wd %h expected none", wd_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_addr_err", {31'h0, addr_err}, {31'h0, e[38]});
                    chk("out_rf_we", {31'h0, rf_we_out}, {31'h0, e[37]});
                    chk("out_wR", {27'h0, wR_out}, {27'h0, e[36:32]});
                    if (e[37]) chk("out_wd", wd_out, e[31:0]);
                end
            end else begin
                chk("idle_addr_err", {31'h0, addr_err}, 32'h0);
            end
        end
    end

    // ---------------- driver with reference model ----------------
    task automatic issue(input bit v, input logic [4:0] wr, input logic [31:0] alu, rd2,
                         input logic [3:0] we, input logic [2:0] op, input bit rfwe,
                         input logic [1:0] sel, input bit ll, sc, clr, output int stalls);
        int sz, cnt;
        bit mis, fail;
        logic [31:0] wd, ld, pc4, ext, wdat, a;
        logic [3:0]  strb;
        pc4 = $urandom;
        ext = $urandom;
        if (v) begin
            sz   = acc_size(we, op);
            mis  = (sz != 0) && ((alu % sz) != 0);
            fail = sc && !m_link && !mis;
            case (sel)
                2'd0: wd = alu;
                2'd2: wd = pc4;
                2'd3: wd = ext;
                default: wd = 32'h0;
            endcase
            if (mis) begin
                exp_q.push_back({1'b1, 1'b0, wr, wd});
                if (sc) m_link = 1'b0;
            end else if (fail) begin
                exp_q.push_back({1'b0, rfwe, wr, 32'h0});
                m_link = 1'b0;
            end else if (sz != 0) begin
                if (we != 4'b0000) begin
                    strb = 4'h0;
                    for (int k = 0; k < sz; k++) begin
                        a = alu + k;
                        strb[a % 4] = 1'b1;
                        gold_b[a] = rd2[8*k +: 8];
                    end
                    for (int i = 0; i < 4; i++) wdat[8*i +: 8] = rd2[8*(i % sz) +: 8];
                    bus_q.push_back({1'b1, strb, alu & 32'hFFFF_FFFC, wdat});
                end else begin
                    ld = 32'h0;
                    for (int k = 0; k < sz; k++) ld[8*k +: 8] = gold_byte(alu + k);
                    if (op == 3'd1 && ld[7])  ld = ld | 32'hFFFF_FF00;
                    if (op == 3'd3 && ld[15]) ld = ld | 32'hFFFF_0000;
                    if (sel == 2'd1) wd = ld;
                    bus_q.push_back({1'b0, 4'h0, alu & 32'hFFFF_FFFC, 32'h0});
                end
                if (sc) wd = 32'h1;
                if (ll) m_link = 1'b1;
                if (sc) m_link = 1'b0;
                exp_q.push_back({1'b0, rfwe, wr, wd});
            end else begin
                exp_q.push_back({1'b0, rfwe, wr, wd});
            end
            if (clr) m_link = 1'b0;
        end
        valid_in = v; wR_in = wr; alu_C_in = alu; rD2_in = rd2; pc4_in = pc4; ext_in = ext;
        ram_we_in = we; ram_ext_op_in = op; rf_we_in = rfwe; wd_sel_in = sel;
        ll_in = ll; sc_in = sc; llbit_clr = clr;
        stalls = 0;
        cnt = 0;
        @(negedge cpu_clk);
        while (mem_stall === 1'b1 && cnt < 64) begin
            stalls++;
            cnt++;
            @(negedge cpu_clk);
        end
        if (cnt >= 64) begin
            n_vec++; n_err++;
            $display("FAIL issue_timeout: got mem_stall stuck for %0d cycles expected release", cnt);
        end
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; ram_we_in = 4'h0; ram_ext_op_in = 3'h0;
        ll_in = 1'b0; sc_in = 1'b0; llbit_clr = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int st, rc, kind, sz, off;
        logic [3:0]  we;
        logic [2:0]  op;
        logic [1:0]  sel;
        logic [31:0] alu;
        bit rfwe, ll, sc, v;

        // reset state
        #1;
        chk("rst_valid_out", {31'h0, valid_out}, 32'h0);
        chk("rst_wd_out", wd_out, 32'h0);
        chk("rst_addr_err", {31'h0, addr_err}, 32'h0);
        chk("rst_dram_req", {31'h0, dram_bus.dram_req}, 32'h0);
        chk("rst_state", {31'h0, dbg_state_o}, 32'h0);
        chk("rst_llbit", {31'h0, dbg_llbit_o}, 32'h0);
        repeat (2) @(negedge cpu_clk);
        cpu_rst = 1'b0;
        @(posedge cpu_clk);
        #1;

        // 1) plain ALU result passes in one cycle without stalling
        issue(1, 5'd3, 32'h1234, 32'h0, 4'h0, 3'h0, 1, 2'd0, 0, 0, 0, st);
        chk("t1_stalls", st, 0);
        chk("t1_wd", wd_out, 32'h1234);
        chk("t1_valid", {31'h0, valid_out}, 32'h1);

        // 2) LB at byte 3 with the ack three cycles late
        ram_w[32'h1000] = 32'h80FF_FF7F;
        gold_b[32'h1000] = 8'h7F; gold_b[32'h1001] = 8'hFF;
        gold_b[32'h1002] = 8'hFF; gold_b[32'h1003] = 8'h80;
        force_delay = 3;
        issue(1, 5'd4, 32'h1003, 32'h0, 4'h0, 3'd1, 1, 2'd1, 0, 0, 0, st);
        chk("t2_stalls", st, 4);
        chk("t2_wd", wd_out, 32'hFFFF_FF80);
        force_delay = 0;

        // 3) SH to the upper half of a word
        issue(1, 5'd0, 32'h2002, 32'h0000_ABCD, 4'b0011, 3'h0, 0, 2'd0, 0, 0, 0, st);
        chk("t3_wstrb", {28'h0, last_wstrb}, 32'h0000_000C);
        chk("t3_wdata", last_wdata, 32'hABCD_ABCD);
        chk("t3_addr", last_addr, 32'h0000_2000);
        chk("t3_wr", {31'h0, last_wr}, 32'h1);

        // 4) LL then SC succeeds, a second SC fails with no bus request
        issue(1, 5'd5, 32'h40, 32'h0, 4'h0, 3'd5, 1, 2'd1, 1, 0, 0, st);
        chk("t4_llbit_set", {31'h0, dbg_llbit_o}, 32'h1);
        rc = req_cnt;
        issue(1, 5'd6, 32'h40, 32'h1357_9BDF, 4'b1111, 3'h0, 1, 2'd0, 0, 1, 0, st);
        chk("t4_sc_wd", wd_out, 32'h1);
        chk("t4_sc_req", req_cnt, rc + 1);
        rc = req_cnt;
        issue(1, 5'd7, 32'h40, 32'h2468_ACE0, 4'b1111, 3'h0, 1, 2'd0, 0, 1, 0, st);
        chk("t4_sc2_wd", wd_out, 32'h0);
        chk("t4_sc2_req", req_cnt, rc);

        // 5) misaligned LW, then LL racing with a link clear
        rc = req_cnt;
        issue(1, 5'd8, 32'h41, 32'h0, 4'h0, 3'd5, 1, 2'd1, 0, 0, 0, st);
        chk("t5_addr_err", {31'h0, addr_err}, 32'h1);
        chk("t5_rf_we", {31'h0, rf_we_out}, 32'h0);
        chk("t5_no_req", req_cnt, rc);
        idle_inputs();
        @(posedge cpu_clk);
        #1;
        chk("t5_pulse_end", {31'h0, addr_err}, 32'h0);
        issue(1, 5'd9, 32'h80, 32'h0, 4'h0, 3'd5, 1, 2'd1, 1, 0, 1, st);
        chk("t5_clr_wins", {31'h0, dbg_llbit_o}, 32'h0);
        force_delay = -1;

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 11);
            v = 1; we = 4'h0; op = 3'h0; rfwe = 1; sel = 2'd1; ll = 0; sc = 0;
            case (kind)
                0, 1, 2: begin
                    sel = ($urandom_range(0, 2) == 0) ? 2'd0 : (($urandom_range(0, 1) == 0) ? 2'd2 : 2'd3);
                    rfwe = 1'($urandom_range(0, 1));
                end
                3:  op = 3'($urandom_range(1, 2));
                4:  op = 3'($urandom_range(3, 4));
                5:  op = 3'd5;
                6:  begin we = 4'b0001; rfwe = 0; sel = 2'd0; end
                7:  begin we = 4'b0011; rfwe = 0; sel = 2'd0; end
                8:  begin we = 4'b1111; rfwe = 0; sel = 2'd0; end
                9:  begin op = 3'd5; ll = 1; end
                10: begin we = 4'b1111; sc = 1; sel = 2'd0; end
                default: begin
                    v = 0; we = 4'($urandom_range(0, 15)); op = 3'($urandom_range(0, 7));
                end
            endcase
            sz  = acc_size(we, op);
            off = $urandom_range(0, 3);
            if (sz != 0 && ($urandom_range(0, 4) != 0 || ll || sc)) off = off & ~(sz - 1);
            alu = (sz != 0 && v) ? (32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'(off)) : $urandom;
            issue(v, 5'($urandom_range(0, 31)), alu, $urandom, we, op, rfwe, sel, ll, sc, 0, st);
        end

        // 6) reset in the middle of a long wait
        force_delay = 0;
        issue(1, 5'd10, 32'h44, 32'h0, 4'h0, 3'd5, 1, 2'd1, 1, 0, 0, st);
        issue(1, 5'd11, 32'hC0DE, 32'h0, 4'h0, 3'h0, 1, 2'd0, 0, 0, 0, st);
        force_delay = 10;
        valid_in = 1'b1; wR_in = 5'd12; alu_C_in = 32'h108; ram_we_in = 4'h0;
        ram_ext_op_in = 3'd5; rf_we_in = 1'b1; wd_sel_in = 2'd1; ll_in = 1'b0; sc_in = 1'b0;
        repeat (3) @(posedge cpu_clk);
        #3;
        chk("t6_in_req", {31'h0, dram_bus.dram_req}, 32'h1);
        cpu_rst = 1'b1;
        #1;
        chk("t6_req_drop", {31'h0, dram_bus.dram_req}, 32'h0);
        chk("t6_stall", {31'h0, mem_stall}, 32'h0);
        chk("t6_wd", wd_out, 32'h0);
        chk("t6_wR", {27'h0, wR_out}, 32'h0);
        chk("t6_llbit", {31'h0, dbg_llbit_o}, 32'h0);
        idle_inputs();
        exp_q.delete();
        bus_q.delete();
        m_link = 1'b0;
        wait_left = -1;
        force_delay = -1;
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
        chk("t6_state_idle", {31'h0, dbg_state_o}, 32'h0);
        chk("t6_req_idle", {31'h0, dram_bus.dram_req}, 32'h0);
        @(posedge cpu_clk);
        #1;
        issue(1, 5'd13, 32'h108, 32'h0, 4'h0, 3'd5, 1, 2'd1, 0, 0, 0, st);
        idle_inputs();

        repeat (5) @(posedge cpu_clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("bus_q_drained", bus_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
